unidad_control_riesgos: RTL

//  Hazard/stall scheduler for the 5-stage MIPS pipeline. Drives enable/flush/bubble

---
 rtl/unidad_control_riesgos.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/unidad_control_riesgos.sv
// Hazard/stall scheduler for the 5-stage MIPS pipeline.
// Drives the enable/flush/bubble controls of the PC and the pipeline buffers.
// It handles load-use stalls, taken-branch flushes and variable-latency
// data-memory waits. A memory wait that runs too long ends in a sticky error.
// It also keeps saturating performance counters.
//
// Ports:
//   clk, reset (async, active-high)
//   leer_mem_EX, reg_destino_EX    load in EX and its destination register
//   rs_ID, rt_ID, usa_rt_ID        source registers of the instruction in ID
//   salto_tomado_EX                branch/jump resolved taken in EX
//   solicitud_mem_MEM, listo_mem   data-memory request / completion
//   escribir_PC .. burbuja_MEM_WB  pipeline controls (combinational)
//   error_timeout                  sticky memory-timeout flag
//   cont_bloqueos, cont_vaciados   saturating stall / flush counters
// MAX_ESPERA must be at least 2.
module unidad_control_riesgos #(
  parameter int unsigned ANCHO_CONT = 16,
  parameter int unsigned MAX_ESPERA = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  leer_mem_EX,
  input  logic [4:0]            reg_destino_EX,
  input  logic [4:0]            rs_ID,
  input  logic [4:0]            rt_ID,
  input  logic                  usa_rt_ID,
  input  logic                  salto_tomado_EX,
  input  logic                  solicitud_mem_MEM,
  input  logic                  listo_mem,
  output logic                  escribir_PC,
  output logic                  escribir_IF_ID,
  output logic                  limpiar_IF_ID,
  output logic                  habilitar_ID_EX,
  output logic                  limpiar_ID_EX,
  output logic                  habilitar_EX_MEM,
  output logic                  burbuja_MEM_WB,
  output logic                  error_timeout,
  output logic [ANCHO_CONT-1:0] cont_bloqueos,
  output logic [ANCHO_CONT-1:0] cont_vaciados
);

  localparam int unsigned AnchoEspera = $clog2(MAX_ESPERA + 1);

  typedef enum logic [1:0] {Correr, EsperaMem, Error} estado_t;

  estado_t                estado_q, estado_d;
  logic [AnchoEspera-1:0] espera_q, espera_d;
  logic [AnchoEspera-1:0] espera_inc;
  logic                   error_q, error_d;

  logic mem_espera;
  logic carga_uso;
  logic salto_aplicado;
  logic carga_aplicada;

  assign espera_inc = espera_q + AnchoEspera'(1);

  // Control outputs: priority ERROR > memory wait > branch > load-use.
  always_comb begin
    mem_espera = solicitud_mem_MEM & ~listo_mem & (estado_q != Error);
    carga_uso  = leer_mem_EX & (|reg_destino_EX) &
                 ((reg_destino_EX == rs_ID) | (usa_rt_ID & (reg_destino_EX == rt_ID)));

    escribir_PC      = 1'b1;
    escribir_IF_ID   = 1'b1;
    limpiar_IF_ID    = 1'b0;
    habilitar_ID_EX  = 1'b1;
    limpiar_ID_EX    = 1'b0;
    habilitar_EX_MEM = 1'b1;
    burbuja_MEM_WB   = 1'b0;
    salto_aplicado   = 1'b0;
    carga_aplicada   = 1'b0;

    if (reset) begin
      escribir_PC      = 1'b0;
      escribir_IF_ID   = 1'b0;
      habilitar_ID_EX  = 1'b0;
      habilitar_EX_MEM = 1'b0;
    end else if ((estado_q == Error) || mem_espera) begin
      // Freeze everything; MEM/WB gets a bubble so a stalled access never writes back.
      escribir_PC      = 1'b0;
      escribir_IF_ID   = 1'b0;
      habilitar_ID_EX  = 1'b0;
      habilitar_EX_MEM = 1'b0;
      burbuja_MEM_WB   = 1'b1;
    end else if (salto_tomado_EX) begin
      // The ID instruction is squashed, so any load-use match is irrelevant.
      limpiar_IF_ID  = 1'b1;
      limpiar_ID_EX  = 1'b1;
      salto_aplicado = 1'b1;
    end else if (carga_uso) begin
      escribir_PC    = 1'b0;
      escribir_IF_ID = 1'b0;
      limpiar_ID_EX  = 1'b1;
      carga_aplicada = 1'b1;
    end
  end

  // Next-state logic for the memory-wait FSM.
  always_comb begin
    estado_d = estado_q;
    espera_d = espera_q;
    error_d  = error_q;
    unique case (estado_q)
      Correr: begin
        if (mem_espera) begin
          estado_d = EsperaMem;
          espera_d = AnchoEspera'(1);
        end
      end
      EsperaMem: begin
        // A dropped request counts as completion, same as listo_mem.
        if (!mem_espera) begin
          estado_d = Correr;
          espera_d = '0;
        end else begin
          espera_d = espera_inc;
          if (espera_inc == AnchoEspera'(MAX_ESPERA)) begin
            estado_d = Error;
            error_d  = 1'b1;
          end
        end
      end
      Error: begin
        error_d = 1'b1;
      end
      default: begin
        estado_d = Correr;
        espera_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q      <= Correr;
      espera_q      <= '0;
      error_q       <= 1'b0;
      cont_bloqueos <= '0;
      cont_vaciados <= '0;
    end else begin
      estado_q <= estado_d;
      espera_q <= espera_d;
      error_q  <= error_d;
      if ((mem_espera || carga_aplicada) && (cont_bloqueos != '1)) begin
        cont_bloqueos <= cont_bloqueos + ANCHO_CONT'(1);
      end
      if (salto_aplicado && (cont_vaciados != '1)) begin
        cont_vaciados <= cont_vaciados + ANCHO_CONT'(1);
      end
    end
  end

  assign error_timeout = error_q;

endmodule
